// File: rtl/decode_pipe_ctrl.sv
// Handshaked decode stage: decodes one instruction into a registered control bundle and
// stalls load-use dependents. Optional illegal-encoding trap bit under DECODE_ILLEGAL_TRAP_EN.
module decode_pipe_ctrl #(
   parameter int PC_W             = 12,
   parameter int LOAD_USE_BUBBLES = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_insn,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_insn,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      out_alu_op,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [11:0]     out_ctrl
);

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_BEX  = 5'b10110;
   localparam logic [4:0] OP_SETX = 5'b10101;

   function automatic logic is_legal(input logic [31:0] insn);
      case (insn[31:27])
         OP_R:    return insn[6:2] <= 5'd5;
         OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_J,
         OP_JAL, OP_JR, OP_BEX, OP_SETX: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [11:0] dec_ctrl(input logic [31:0] insn);
      logic [11:0] c;
      c = '0;
      case (insn[31:27])
         OP_R:    c[0] = is_legal(insn);
         OP_ADDI: begin c[0] = 1'b1; c[3] = 1'b1; end
         OP_LW:   begin c[0] = 1'b1; c[1] = 1'b1; c[3] = 1'b1; end
         OP_SW:   begin c[2] = 1'b1; c[3] = 1'b1; end
         OP_BNE:  c[4] = 1'b1;
         OP_BLT:  c[5] = 1'b1;
         OP_J:    c[6] = 1'b1;
         OP_JAL:  begin c[0] = 1'b1; c[7] = 1'b1; end
         OP_JR:   c[8] = 1'b1;
         OP_BEX:  c[9] = 1'b1;
         OP_SETX: begin c[0] = 1'b1; c[10] = 1'b1; end
         default: c = '0;
      endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
      c[11] = ~is_legal(insn);
`else
      c[11] = 1'b0;
`endif
      return c;
   endfunction

   function automatic logic [4:0] dec_alu(input logic [31:0] insn);
      case (insn[31:27])
         OP_R:           return insn[6:2];
         OP_BNE, OP_BLT: return 5'b00001;
         default:        return 5'b00000;
      endcase
   endfunction

   // Register 0 and illegal encodings never create a dependency.
   function automatic logic reads_reg(input logic [31:0] insn, input logic [4:0] r);
      logic rd_hit, rs_hit, rt_hit;
      rd_hit = insn[26:22] == r;
      rs_hit = insn[21:17] == r;
      rt_hit = insn[16:12] == r;
      if (r == 5'd0 || !is_legal(insn)) return 1'b0;
      case (insn[31:27])
         OP_R:                  return rs_hit | rt_hit;
         OP_ADDI, OP_LW:        return rs_hit;
         OP_SW, OP_BNE, OP_BLT: return rd_hit | rs_hit;
         OP_JR:                 return rd_hit;
         default:               return 1'b0;
      endcase
   endfunction

   logic [2:0] bub_cnt;
   logic [4:0] lw_rd;
   logic       held_lw;
   logic       hazard;
   logic       xfer_in;
   logic       xfer_out;

   assign held_lw  = out_valid & out_ctrl[1];
   assign hazard   = in_valid & ((held_lw & reads_reg(in_insn, out_rd)) |
                                 ((bub_cnt != 3'd0) & reads_reg(in_insn, lw_rd)));
   // Valid/ready: a beat moves when valid & ready are both high at the rising edge;
   // in_ready already excludes flush, so a flushed cycle never accepts.
   assign in_ready = ~reset & ~flush & (~out_valid | out_ready) & ~hazard;
   assign xfer_in  = in_valid & in_ready;
   assign xfer_out = out_valid & out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid  <= 1'b0;
         bub_cnt    <= 3'd0;
         lw_rd      <= 5'd0;
         out_insn   <= '0;
         out_pc     <= '0;
         out_alu_op <= '0;
         out_rd     <= '0;
         out_rs     <= '0;
         out_rt     <= '0;
         out_ctrl   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         bub_cnt   <= 3'd0;
      end else begin
         if (xfer_in) begin
            out_valid  <= 1'b1;
            out_insn   <= in_insn;
            out_pc     <= in_pc;
            out_alu_op <= dec_alu(in_insn);
            out_rd     <= in_insn[26:22];
            out_rs     <= in_insn[21:17];
            out_rt     <= in_insn[16:12];
            out_ctrl   <= dec_ctrl(in_insn);
         end else if (xfer_out) begin
            out_valid <= 1'b0;
         end
         // A lw leaving the stage opens the bubble window for its destination.
         if (xfer_out && out_ctrl[1]) begin
            bub_cnt <= 3'(LOAD_USE_BUBBLES);
            lw_rd   <= out_rd;
         end else if (bub_cnt != 3'd0) begin
            bub_cnt <= bub_cnt - 3'd1;
         end
      end
   end

endmodule
